renesas_cfg_seq: RTL
====================

RENESAS_CFG_SEQ -- requirements
Module: renesas_cfg_seq

Interface
REQ-001 Parameters SHALL be: DEVICE_ID, default 8'hB0, 7-bit target address in [7:1] with bit0 = 0; NUM_ENTRIES, default 256, number of table entries (1..1024); MAX_RETRY, default 3, NACK retries allowed per entry (0..15).
REQ-002 Ports SHALL be exactly, as name direction width meaning:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to run the table
- rom_addr  out  10  table entry index
- rom_data  in  16  {reg_addr[15:8], wr_data[7:0]}, valid exactly 1 cycle after rom_addr changes
- m_valid  out  1  byte command valid
- m_ready  in  1  byte master accepts the command
- m_start  out  1  issue START before m_byte
- m_stop  out  1  issue STOP after m_byte
- m_byte  out  8  byte to transmit
- m_resp_valid  in  1  ACK/NACK result valid for the last accepted byte
- m_nack  in  1  result was NACK (qualified by m_resp_valid)
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky; retries exhausted
- err_index  out  10  entry index that failed

Function
REQ-003 FSM states SHALL be IDLE, FETCH, WAIT_ROM, SEND_DEV, SEND_REG, SEND_DATA, WAIT_RESP, NEXT, DONE, ERR.
REQ-004 IDLE -> FETCH SHALL occur on start=1; start SHALL be ignored in every other state.
REQ-005 FETCH SHALL drive rom_addr = idx; WAIT_ROM SHALL capture rom_data on the next cycle, giving 2 cycles from FETCH entry to SEND_DEV.
REQ-006 Each entry SHALL be sent as three commands: DEVICE_ID with m_start=1; reg_addr; wr_data with m_stop=1.
REQ-007 m_start and m_stop SHALL be 0 on all other commands.
REQ-008 m_valid SHALL assert in each SEND_* state and SHALL stay stable, with m_byte, m_start and m_stop held, until a cycle with m_valid & m_ready.
REQ-009 After each accepted byte the FSM SHALL enter WAIT_RESP and wait, unbounded, for m_resp_valid.
REQ-010 On ACK, WAIT_RESP SHALL advance to the next SEND_* state, or to NEXT after the data byte.
REQ-011 On NACK when retry_cnt < MAX_RETRY, the FSM SHALL increment retry_cnt and restart the same entry at SEND_DEV.
REQ-012 On NACK when retry_cnt = MAX_RETRY, the FSM SHALL latch err_index = idx, set error, and enter ERR.
REQ-013 NEXT SHALL clear retry_cnt. If idx = NUM_ENTRIES-1 it SHALL go to DONE; otherwise it SHALL increment idx and go to FETCH.
REQ-014 DONE SHALL pulse done for 1 cycle, then return to IDLE with idx = 0.
REQ-015 ERR SHALL hold until rst; start SHALL be ignored in ERR.
REQ-016 busy SHALL be 1 in every state except IDLE and ERR.
REQ-017 m_resp_valid arriving outside WAIT_RESP SHALL be ignored.
REQ-018 m_ready with m_valid=0 SHALL be ignored.

Reset
REQ-019 On rst=1 at a clk edge, the block SHALL enter IDLE and set idx=0, retry_cnt=0, rom_addr=0, m_valid=0, m_start=0, m_stop=0, m_byte=0, busy=0, done=0, error=0, err_index=0.
REQ-020 rst mid-transaction SHALL abandon the transaction without generating a STOP; bus recovery belongs to the byte master.

Configuration
REQ-021 Macro CFG_SEQ_EOT_EN SHALL control end-of-table detection.
- Defined: an entry equal to 16'hFFFF SHALL be treated as end-of-table. WAIT_ROM SHALL go directly to DONE with no bus traffic for that entry.
- Undefined: 16'hFFFF SHALL be sent as a normal write (reg FF, data FF).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- V1: NUM_ENTRIES=2, table {0x0102, 0x0304}, all ACK -> bytes B0(start),01,02(stop),B0(start),03,04(stop); done pulses once; error=0.
- V2: entry 0 NACKed on its device byte twice, then ACK, MAX_RETRY=3 -> B0 sent 3 times; entry completes; done=1; error=0.
- V3: every response NACK, MAX_RETRY=3 -> 4 attempts; error=1; err_index=0; busy=0; a later start is ignored.
- V4: m_ready held low 5 cycles on the reg byte -> m_valid and m_byte=reg_addr stay stable all 5 cycles; no duplicate byte.
- V5: rst asserted while in WAIT_RESP on entry 1 -> next cycle all outputs at reset values; a fresh start replays from entry 0.
- V6 (CFG_SEQ_EOT_EN defined): table {0x1020, 0xFFFF, 0x3040} -> only the 0x10/0x20 write is issued, then done; with the macro undefined, three writes are issued.

Source files
------------

// File: rtl/renesas_cfg_seq.sv
`default_nettype none
// ============================================================================
//  Module   : renesas_cfg_seq
//  Brief    : Walks a register table from ROM and issues each entry as a
//             three-byte I2C-style write (device, register, data) through a
//             byte master, with per-entry NACK retry and sticky error.
//             Build option CFG_SEQ_EOT_EN: treat 16'hFFFF entries as end-of-table.
//  Revision : 1.0  initial release
// ============================================================================
module renesas_cfg_seq #(
    parameter int DEVICE_ID   = 8'hB0,
    parameter int NUM_ENTRIES = 256,
    parameter int MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [9:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_start,
    output logic        m_stop,
    output logic [7:0]  m_byte,
    input  logic        m_resp_valid,
    input  logic        m_nack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [9:0]  err_index
);

    localparam logic [7:0] c_dev_byte  = 8'(DEVICE_ID);
    localparam logic [9:0] c_last_idx  = 10'(NUM_ENTRIES - 1);
    localparam logic [3:0] c_max_retry = 4'(MAX_RETRY);

    localparam logic [1:0] c_ph_dev  = 2'd0;
    localparam logic [1:0] c_ph_reg  = 2'd1;
    localparam logic [1:0] c_ph_data = 2'd2;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        WAIT_ROM  = 4'd2,
        SEND_DEV  = 4'd3,
        SEND_REG  = 4'd4,
        SEND_DATA = 4'd5,
        WAIT_RESP = 4'd6,
        NEXT      = 4'd7,
        DONE      = 4'd8,
        ERR       = 4'd9
    } state_t;

    state_t     r_state;
    logic [9:0] r_idx;
    logic [3:0] r_retry_cnt;
    logic [1:0] r_phase;
    logic [7:0] r_reg_addr;
    logic [7:0] r_wr_data;
    logic [9:0] r_rom_addr;
    logic       r_m_valid;
    logic       r_m_start;
    logic       r_m_stop;
    logic [7:0] r_m_byte;
    logic       r_busy;
    logic       r_done;
    logic       r_error;
    logic [9:0] r_err_index;
    logic       w_eot;

`ifdef CFG_SEQ_EOT_EN
    assign w_eot = (rom_data == 16'hFFFF);
`else
    assign w_eot = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= 10'd0;
            r_retry_cnt <= 4'd0;
            r_phase     <= c_ph_dev;
            r_reg_addr  <= 8'd0;
            r_wr_data   <= 8'd0;
            r_rom_addr  <= 10'd0;
            r_m_valid   <= 1'b0;
            r_m_start   <= 1'b0;
            r_m_stop    <= 1'b0;
            r_m_byte    <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_index <= 10'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rom_addr <= r_idx;
                        r_busy     <= 1'b1;
                        r_state    <= FETCH;
                    end
                end

                FETCH: begin
                    r_state <= WAIT_ROM;
                end

                // ROM output for r_rom_addr is valid during this cycle
                WAIT_ROM: begin
                    r_reg_addr <= rom_data[15:8];
                    r_wr_data  <= rom_data[7:0];
                    if (w_eot) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_m_valid <= 1'b1;
                        r_m_start <= 1'b1;
                        r_m_stop  <= 1'b0;
                        r_m_byte  <= c_dev_byte;
                        r_phase   <= c_ph_dev;
                        r_state   <= SEND_DEV;
                    end
                end

                SEND_DEV, SEND_REG, SEND_DATA: begin
                    if (r_m_valid && m_ready) begin
                        r_m_valid <= 1'b0;
                        r_m_start <= 1'b0;
                        r_m_stop  <= 1'b0;
                        r_state   <= WAIT_RESP;
                    end
                end

                WAIT_RESP: begin
                    if (m_resp_valid) begin
                        if (m_nack) begin
                            if (r_retry_cnt < c_max_retry) begin
                                r_retry_cnt <= r_retry_cnt + 4'd1;
                                r_m_valid   <= 1'b1;
                                r_m_start   <= 1'b1;
                                r_m_stop    <= 1'b0;
                                r_m_byte    <= c_dev_byte;
                                r_phase     <= c_ph_dev;
                                r_state     <= SEND_DEV;
                            end else begin
                                r_error     <= 1'b1;
                                r_err_index <= r_idx;
                                r_busy      <= 1'b0;
                                r_state     <= ERR;
                            end
                        end else begin
                            case (r_phase)
                                c_ph_dev: begin
                                    r_m_valid <= 1'b1;
                                    r_m_byte  <= r_reg_addr;
                                    r_phase   <= c_ph_reg;
                                    r_state   <= SEND_REG;
                                end
                                c_ph_reg: begin
                                    r_m_valid <= 1'b1;
                                    r_m_stop  <= 1'b1;
                                    r_m_byte  <= r_wr_data;
                                    r_phase   <= c_ph_data;
                                    r_state   <= SEND_DATA;
                                end
                                default: begin
                                    r_state <= NEXT;
                                end
                            endcase
                        end
                    end
                end

                NEXT: begin
                    r_retry_cnt <= 4'd0;
                    if (r_idx == c_last_idx) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx      <= r_idx + 10'd1;
                        r_rom_addr <= r_idx + 10'd1;
                        r_state    <= FETCH;
                    end
                end

                DONE: begin
                    r_idx   <= 10'd0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                // Only rst leaves ERR; start is deliberately not decoded here
                ERR: begin
                    r_state <= ERR;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rom_addr  = r_rom_addr;
    assign m_valid   = r_m_valid;
    assign m_start   = r_m_start;
    assign m_stop    = r_m_stop;
    assign m_byte    = r_m_byte;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign err_index = r_err_index;

endmodule
`default_nettype wire
